// File: rtl/eight_data_decompress_unit.sv
// Eight-lane decompressor: turns one packed, tagged beat back into eight full-width words.
// Three wrtEn-gated register stages: S1 tag/offset decode, S2 per-lane byte alignment, S3 mask/extend.
module eight_data_decompress_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wrtEn,
  input  logic [3:0]                flags_in,
  input  logic [8*DATA_WIDTH-1:0]   dataIn,
  input  logic [8*TAG_WIDTH-1:0]    tagIn,
  input  logic [LEN_WIDTH-1:0]      lenIn,
  output logic [8*DATA_WIDTH-1:0]   dataOut,
  output logic [3:0]                flags_out,
  output logic                      lenErr
);

  localparam int NUM_LANES = 8;
  localparam int BUS_WIDTH = NUM_LANES * DATA_WIDTH;
  localparam int TAG_BUS   = NUM_LANES * TAG_WIDTH;
  localparam int OFF_WIDTH = 5;
  localparam int TOT_WIDTH = 6;

  // flags bit positions: {valid, tlast, flag_compression, is_header}
  localparam int F_VALID  = 3;
  localparam int F_COMP   = 1;
  localparam int F_HEADER = 0;

  // Flow control: there is no valid/ready handshake. wrtEn is the sole
  // advance strobe; when it is low every register (data, flags, lenErr)
  // holds, and when high one beat moves one stage. No backpressure exists.

  function automatic logic [TOT_WIDTH-1:0] tagLen(input logic [TAG_WIDTH-1:0] tag);
    case (tag)
      2'b00:   return TOT_WIDTH'(0);
      2'b01:   return TOT_WIDTH'(1);
      2'b10:   return TOT_WIDTH'(2);
      default: return TOT_WIDTH'(4);
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extendLane(
    input logic [TAG_WIDTH-1:0]  tag,
    input logic [DATA_WIDTH-1:0] raw
  );
    case (tag)
      2'b00:   return '0;
      2'b01:   return {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      2'b10:   return {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Stage 1 next-state: effective tags, prefix byte offsets, length check
  logic                                 bypass;
  logic [TAG_BUS-1:0]                   effTag;
  logic [NUM_LANES-1:0][OFF_WIDTH-1:0]  offNext;
  logic [TOT_WIDTH-1:0]                 acc;
  logic [TOT_WIDTH-1:0]                 total;
  logic [LEN_WIDTH-1:0]                 expLen;
  logic                                 misNext;

  // Stage registers
  logic [BUS_WIDTH-1:0]                 s1Data;
  logic [TAG_BUS-1:0]                   s1Tag;
  logic [NUM_LANES-1:0][OFF_WIDTH-1:0]  s1Off;
  logic [3:0]                           s1Flags;
  logic                                 s1Mis;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] s2Next;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] s2Word;
  logic [TAG_BUS-1:0]                   s2Tag;
  logic [3:0]                           s2Flags;
  logic                                 s2Mis;

  logic [BUS_WIDTH-1:0]                 outNext;

  always_comb begin : s1Decode
    bypass  = ~flags_in[F_COMP] | flags_in[F_HEADER];
    effTag  = '0;
    offNext = '0;
    acc     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      effTag[i*TAG_WIDTH +: TAG_WIDTH] = bypass ? {TAG_WIDTH{1'b1}}
                                                : tagIn[i*TAG_WIDTH +: TAG_WIDTH];
      offNext[i] = acc[OFF_WIDTH-1:0];
      acc = acc + tagLen(effTag[i*TAG_WIDTH +: TAG_WIDTH]);
    end
    total   = acc;
    // Compressed beats also carry the two tag bytes in their length.
    expLen  = bypass ? LEN_WIDTH'(32) : LEN_WIDTH'(total) + LEN_WIDTH'(2);
    misNext = flags_in[F_VALID] & (lenIn != expLen);
  end

  always_comb begin : s2Align
    s2Next = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      s2Next[i] = DATA_WIDTH'(s1Data >> {s1Off[i], 3'b000});
    end
  end

  always_comb begin : s3Extend
    outNext = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      outNext[i*DATA_WIDTH +: DATA_WIDTH] =
        s2Flags[F_VALID] ? extendLane(s2Tag[i*TAG_WIDTH +: TAG_WIDTH], s2Word[i]) : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Data    <= '0;
      s1Tag     <= '0;
      s1Off     <= '0;
      s1Flags   <= '0;
      s1Mis     <= 1'b0;
      s2Word    <= '0;
      s2Tag     <= '0;
      s2Flags   <= '0;
      s2Mis     <= 1'b0;
      dataOut   <= '0;
      flags_out <= '0;
      lenErr    <= 1'b0;
    end else if (wrtEn) begin
      s1Data    <= dataIn;
      s1Tag     <= effTag;
      s1Off     <= offNext;
      s1Flags   <= flags_in;
      s1Mis     <= misNext;
      s2Word    <= s2Next;
      s2Tag     <= s1Tag;
      s2Flags   <= s1Flags;
      s2Mis     <= s1Mis;
      dataOut   <= outNext;
      flags_out <= s2Flags;
      // Sticky: only reset clears a recorded length mismatch.
      lenErr    <= lenErr | s2Mis;
    end
  end

endmodule

// File: tb/tb_eight_data_decompress_unit.sv
// Directed bench for eight_data_decompress_unit: hand-computed beats, expected-queue scoreboard,
// stall and mid-stream reset scenarios.
module tb_eight_data_decompress_unit;

  logic         clk;
  logic         reset;
  logic         wrtEn;
  logic [3:0]   flags_in;
  logic [255:0] dataIn;
  logic [15:0]  tagIn;
  logic [7:0]   lenIn;
  logic [255:0] dataOut;
  logic [3:0]   flags_out;
  logic         lenErr;

  eight_data_decompress_unit #(
    .DATA_WIDTH(32),
    .TAG_WIDTH (2),
    .LEN_WIDTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wrtEn    (wrtEn),
    .flags_in (flags_in),
    .dataIn   (dataIn),
    .tagIn    (tagIn),
    .lenIn    (lenIn),
    .dataOut  (dataOut),
    .flags_out(flags_out),
    .lenErr   (lenErr)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #90000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  int           vecCount  = 0;
  int           missCount = 0;
  logic [255:0] exp_q[$];
  logic [3:0]   expFlagQ[$];
  logic         expMisQ[$];
  logic [255:0] heldData;
  logic [3:0]   heldFlags;
  logic         heldErr;

  task automatic checkVal(input string name, input logic [255:0] got, input logic [255:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Two zero entries stand for the cleared S1/S2 registers after reset.
  task automatic modelReset();
    exp_q.delete();
    expFlagQ.delete();
    expMisQ.delete();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0);
      expFlagQ.push_back(4'b0000);
      expMisQ.push_back(1'b0);
    end
    heldData  = '0;
    heldFlags = '0;
    heldErr   = 1'b0;
  endtask

  task automatic checkOutputs(input string name);
    checkVal({name, ".data"},  dataOut,           heldData);
    checkVal({name, ".flags"}, 256'(flags_out),   256'(heldFlags));
    checkVal({name, ".err"},   256'(lenErr),      256'(heldErr));
  endtask

  // Driver: present one beat, take one edge, update model, compare.
  task automatic stepBeat(input logic en, input logic [3:0] fl, input logic [255:0] d,
                          input logic [15:0] t, input logic [7:0] l,
                          input logic [255:0] expD, input logic expMis, input string name);
    wrtEn    = en;
    flags_in = fl;
    dataIn   = d;
    tagIn    = t;
    lenIn    = l;
    @(posedge clk);
    #1;
    if (en) begin
      exp_q.push_back(expD);
      expFlagQ.push_back(fl);
      expMisQ.push_back(expMis);
      heldData  = exp_q.pop_front();
      heldFlags = expFlagQ.pop_front();
      heldErr   = heldErr | expMisQ.pop_front();
    end
    checkOutputs(name);
  endtask

  function automatic logic [255:0] rnd();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepBeat(1'b1, 4'b0000, rnd(), 16'h0000, 8'd0, '0, 1'b0, "idle");
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    checkVal("rst.data",  dataOut,         '0);
    checkVal("rst.flags", 256'(flags_out), '0);
    checkVal("rst.err",   256'(lenErr),    '0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    modelReset();
  endtask

  // Hand-built vectors
  logic [255:0] bypassData;
  logic [255:0] mixData;
  logic [255:0] mixExp;
  logic [255:0] sextData;
  logic [255:0] sextExp;
  logic [255:0] r;

  initial begin
    reset = 1'b1; wrtEn = 1'b0; flags_in = '0; dataIn = '0; tagIn = '0; lenIn = '0;
    for (int i = 0; i < 8; i++) bypassData[i*32 +: 32] = i;
    // Bytes 0..13: 78 56 34 12 | 80 FF | 7F | EF BE AD DE | 80 | 01 00; junk above.
    mixData = {{18{8'hA5}}, 112'h000180DEADBEEF7FFF8012345678};
    mixExp  = {32'h00000000, 32'h00000001, 32'hFFFFFF80, 32'hDEADBEEF,
               32'h00000000, 32'h0000007F, 32'hFFFFFF80, 32'h12345678};
    sextData = rnd();
    sextData[63:0] = 64'hFE3CC30001FF7F80;
    sextExp  = {32'hFFFFFFFE, 32'h0000003C, 32'hFFFFFFC3, 32'h00000000,
                32'h00000001, 32'hFFFFFFFF, 32'h0000007F, 32'hFFFFFF80};

    #2;
    checkVal("init.data",  dataOut,         '0);
    checkVal("init.flags", 256'(flags_out), '0);
    checkVal("init.err",   256'(lenErr),    '0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    modelReset();

    // Main decode patterns
    stepBeat(1'b1, 4'b1000, bypassData, 16'h0000, 8'd32, bypassData, 1'b0, "bypass");
    stepBeat(1'b1, 4'b1010, mixData, 16'h271B, 8'd16, mixExp, 1'b0, "mixed");
    r = rnd();
    stepBeat(1'b1, 4'b1110, r, 16'h0000, 8'd2, '0, 1'b0, "allzero");
    r = rnd();
    stepBeat(1'b1, 4'b1011, r, 16'h5555, 8'd32, r, 1'b0, "header");
    stepBeat(1'b1, 4'b0010, mixData, 16'h271B, 8'd99, '0, 1'b0, "invalid");
    r = rnd();
    stepBeat(1'b1, 4'b1010, r, 16'hFFFF, 8'd34, r, 1'b0, "allraw");
    stepBeat(1'b1, 4'b1110, sextData, 16'h5555, 8'd10, sextExp, 1'b0, "sext8");
    idle(2);

    // Stall after the second beat
    stepBeat(1'b1, 4'b1010, mixData, 16'h271B, 8'd16, mixExp, 1'b0, "stA");
    stepBeat(1'b1, 4'b1000, bypassData, 16'h0000, 8'd32, bypassData, 1'b0, "stB");
    for (int i = 0; i < 5; i++)
      stepBeat(1'b0, 4'b1010, rnd(), 16'hFFFF, 8'd7, '0, 1'b1, "stall");
    r = rnd();
    stepBeat(1'b1, 4'b1110, r, 16'h0000, 8'd2, '0, 1'b0, "stC");
    r = rnd();
    stepBeat(1'b1, 4'b1001, r, 16'hAAAA, 8'd32, r, 1'b0, "stD");
    idle(2);

    // Length error is sticky but the beat still decodes
    stepBeat(1'b1, 4'b1010, mixData, 16'h271B, 8'd15, mixExp, 1'b1, "lenerr");
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0)
        stepBeat(1'b1, 4'b1000, bypassData, 16'h0000, 8'd32, bypassData, 1'b0, "good");
      else
        stepBeat(1'b1, 4'b1010, mixData, 16'h271B, 8'd16, mixExp, 1'b0, "good");
    end
    idle(2);
    checkVal("sticky", 256'(lenErr), 256'(1));

    // Reset with three beats in flight
    stepBeat(1'b1, 4'b1010, mixData, 16'h271B, 8'd16, mixExp, 1'b0, "pre1");
    stepBeat(1'b1, 4'b1000, bypassData, 16'h0000, 8'd32, bypassData, 1'b0, "pre2");
    stepBeat(1'b1, 4'b1110, sextData, 16'h5555, 8'd10, sextExp, 1'b0, "pre3");
    doReset();
    stepBeat(1'b1, 4'b1000, bypassData, 16'h0000, 8'd32, bypassData, 1'b0, "post1");
    stepBeat(1'b1, 4'b1010, mixData, 16'h271B, 8'd16, mixExp, 1'b0, "post2");
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
